ncc_search_ctrl: RTL and testbench

- Sequencer for the ncc processing element.
- For each of NUM_POS candidate window positions, in order:
  - fetches the window's pixels from the window buffer;
  - waits out the log2 conversion latency;
  - pulses loadWinReg, then loadAccSumReg;
  - samples the accumulator lanes and reduces them to a score.
- Tracks the best (maximum) score and its position, and reports once per search.

---
 rtl/ncc_search_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ncc_search_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncc_search_ctrl.sv
// rtl/ncc_search_ctrl.sv - search sequencer for the ncc processing element
//
// Steps through NUM_POS candidate window positions. For each position it
// fetches the window, waits for the pixels and the log2 stage, strobes the
// ncc window and accumulator registers, then reduces the accumulator lanes
// to a score. The best (maximum) score and its position are reported once
// per search.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-low reset
//   start          begin a search (accepted only when idle)
//   abort          cancel an in-progress search
//   busy           high while a search is running
//   win_rd_en      one-cycle read request to the window buffer
//   win_rd_addr    position being fetched, held stable while waiting
//   win_rd_valid   window pixels are presented to the log2 stage this cycle
//   loadWinReg     ncc window-register load strobe
//   loadAccSumReg  ncc accumulator load strobe
//   acc_out        ncc accumulator lanes, lane i at [i*ACC_W +: ACC_W]
//   best_score     best lane-sum of the current/last search
//   best_pos       position of best_score
//   result_valid   one-cycle pulse when a search completes

module ncc_search_ctrl #(
   parameter int NUM_LANES = 8,
   parameter int ACC_W     = 16,
   parameter int NUM_POS   = 16,
   parameter int LOG_LAT   = 1,
   parameter int POS_W     = (NUM_POS > 1) ? $clog2(NUM_POS) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic                                  abort,
   output logic                                  busy,
   output logic                                  win_rd_en,
   output logic [POS_W-1:0]                      win_rd_addr,
   input  logic                                  win_rd_valid,
   output logic                                  loadWinReg,
   output logic                                  loadAccSumReg,
   input  logic [NUM_LANES*ACC_W-1:0]            acc_out,
   output logic [ACC_W+$clog2(NUM_LANES)-1:0]    best_score,
   output logic [POS_W-1:0]                      best_pos,
   output logic                                  result_valid
);

   localparam int SCORE_W = ACC_W + $clog2(NUM_LANES);
   localparam int CNT_W   = (LOG_LAT > 1) ? $clog2(LOG_LAT) : 1;

   localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POS - 1);
   localparam logic [CNT_W-1:0] CNT_INIT = (LOG_LAT > 0) ? CNT_W'(LOG_LAT - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_LOGW,
      S_LDWIN,
      S_LDACC,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t             state;
   logic [POS_W-1:0]   pos;
   logic [CNT_W-1:0]   lat_cnt;
   logic [SCORE_W-1:0] score;

   // The fetch address is the position counter itself, so it stays put for
   // the whole time the position is being processed.
   assign win_rd_addr = pos;

   // Full-width lane reduction; SCORE_W leaves room for NUM_LANES maximal
   // lanes so the sum can never wrap.
   always_comb begin
      score = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         score = score + SCORE_W'(acc_out[i*ACC_W +: ACC_W]);
      end
   end

   // Outputs are registered: each transition also sets the strobes that
   // belong to the state being entered, so every strobe is high exactly
   // during its own state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         pos           <= '0;
         lat_cnt       <= '0;
         busy          <= 1'b0;
         win_rd_en     <= 1'b0;
         loadWinReg    <= 1'b0;
         loadAccSumReg <= 1'b0;
         result_valid  <= 1'b0;
         best_score    <= '0;
         best_pos      <= '0;
      end else begin
         win_rd_en     <= 1'b0;
         loadWinReg    <= 1'b0;
         loadAccSumReg <= 1'b0;
         result_valid  <= 1'b0;

         if (abort && state != S_IDLE) begin
            // Abort beats every transition, including SAMPLE->DONE; the best
            // tracker keeps whatever partial values it had.
            state <= S_IDLE;
            busy  <= 1'b0;
            pos   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !abort) begin
                     state      <= S_FETCH;
                     pos        <= '0;
                     busy       <= 1'b1;
                     best_score <= '0;
                     best_pos   <= '0;
                     win_rd_en  <= 1'b1;
                  end
               end

               S_FETCH: begin
                  state <= S_WAIT;
               end

               S_WAIT: begin
                  if (win_rd_valid) begin
                     if (LOG_LAT > 0) begin
                        state   <= S_LOGW;
                        lat_cnt <= CNT_INIT;
                     end else begin
                        state      <= S_LDWIN;
                        loadWinReg <= 1'b1;
                     end
                  end
               end

               // Entered with LOG_LAT-1, leaves on zero: LOG_LAT cycles here.
               S_LOGW: begin
                  if (lat_cnt == '0) begin
                     state      <= S_LDWIN;
                     loadWinReg <= 1'b1;
                  end else begin
                     lat_cnt <= lat_cnt - CNT_W'(1);
                  end
               end

               S_LDWIN: begin
                  state         <= S_LDACC;
                  loadAccSumReg <= 1'b1;
               end

               S_LDACC: begin
                  state <= S_SAMPLE;
               end

               S_SAMPLE: begin
                  // Position 0 seeds the tracker; later positions replace it
                  // only on a strictly larger score so ties keep the earlier one.
                  if (pos == '0 || score > best_score) begin
                     best_score <= score;
                     best_pos   <= pos;
                  end
                  if (pos == LAST_POS) begin
                     state        <= S_DONE;
                     result_valid <= 1'b1;
                  end else begin
                     state     <= S_FETCH;
                     pos       <= pos + POS_W'(1);
                     win_rd_en <= 1'b1;
                  end
               end

               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  pos   <= '0;
               end

               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  pos   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ncc_search_ctrl.sv
// tb/tb_ncc_search_ctrl.sv - self-checking bench for ncc_search_ctrl

module tb_ncc_search_ctrl;

   localparam int NUM_LANES = 8;
   localparam int ACC_W     = 16;
   localparam int NUM_POS   = 16;
   localparam int LOG_LAT   = 1;
   localparam int POS_W     = 4;
   localparam int SCORE_W   = ACC_W + 3;

   logic                       clk;
   logic                       rst;
   logic                       start;
   logic                       abort;
   logic                       busy;
   logic                       win_rd_en;
   logic [POS_W-1:0]           win_rd_addr;
   logic                       win_rd_valid;
   logic                       loadWinReg;
   logic                       loadAccSumReg;
   logic [NUM_LANES*ACC_W-1:0] acc_out;
   logic [SCORE_W-1:0]         best_score;
   logic [POS_W-1:0]           best_pos;
   logic                       result_valid;

   int checks;
   int errors;

   logic [ACC_W-1:0] lane_val [NUM_POS][NUM_LANES];
   int               dly      [NUM_POS];

   typedef struct {
      int                 kind;
      int                 slow_pos;
      bit                 start_mid;
      bit                 start_on_rv;
      logic [SCORE_W-1:0] exp_score;
      logic [POS_W-1:0]   exp_pos;
      int                 exp_rv;
   } vec_t;

   vec_t vecs [5];

   ncc_search_ctrl #(
      .NUM_LANES(NUM_LANES),
      .ACC_W(ACC_W),
      .NUM_POS(NUM_POS),
      .LOG_LAT(LOG_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .busy(busy),
      .win_rd_en(win_rd_en),
      .win_rd_addr(win_rd_addr),
      .win_rd_valid(win_rd_valid),
      .loadWinReg(loadWinReg),
      .loadAccSumReg(loadAccSumReg),
      .acc_out(acc_out),
      .best_score(best_score),
      .best_pos(best_pos),
      .result_valid(result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accumulator lanes follow the position currently addressed.
   always_comb begin
      acc_out = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         acc_out[l*ACC_W +: ACC_W] = lane_val[win_rd_addr][l];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic void set_sum(input int p, input int v);
      for (int l = 0; l < NUM_LANES; l++) begin
         lane_val[p][l] = ACC_W'(v / NUM_LANES + ((l == 0) ? v % NUM_LANES : 0));
      end
   endfunction

   function automatic void setup(input int kind, input int slow_pos);
      for (int p = 0; p < NUM_POS; p++) begin
         dly[p] = (p == slow_pos) ? 4 : 1;
         case (kind)
            0: set_sum(p, 8 * p);
            1: set_sum(p, (p == 5 || p == 9) ? 900 : 10 * p);
            2: set_sum(p, 0);
            default: for (int l = 0; l < NUM_LANES; l++) lane_val[p][l] = 16'hFFFF;
         endcase
      end
   endfunction

   // Reference: first position holding the maximum plain-integer lane sum.
   function automatic void ref_best(output logic [SCORE_W-1:0] bs, output logic [POS_W-1:0] bp);
      longint best;
      best = -1;
      bp   = '0;
      for (int p = 0; p < NUM_POS; p++) begin
         longint s;
         s = 0;
         for (int l = 0; l < NUM_LANES; l++) s += longint'(lane_val[p][l]);
         if (s > best) begin
            best = s;
            bp   = POS_W'(p);
         end
      end
      bs = SCORE_W'(best);
   endfunction

   task automatic run_search(input string nm, input int abort_at, input bit start_mid,
                             input bit start_on_rv, input logic [SCORE_W-1:0] exp_score,
                             input logic [POS_W-1:0] exp_pos, input int exp_rv);
      int fetch_c[$];
      int fetch_a[$];
      int ldwin_c[$];
      int ldacc_c[$];
      int rv_c[$];
      int ef_c[$];
      int ef_a[$];
      int ew_c[$];
      int ea_c[$];
      int t, valid_at, cyc, last_addr, end_cyc, exp_end;
      bit excl_bad, hold_bad;

      // Expected timeline: each position costs fetch + wait + log2 latency
      // + window load + acc load + sample.
      t = 1;
      for (int p = 0; p < NUM_POS; p++) begin
         int w;
         w = t + dly[p] + LOG_LAT + 1;
         if (abort_at < 0 || t <= abort_at) begin
            ef_c.push_back(t);
            ef_a.push_back(p);
         end
         if (abort_at < 0 || w <= abort_at) ew_c.push_back(w);
         if (abort_at < 0 || w + 1 <= abort_at) ea_c.push_back(w + 1);
         t += 4 + LOG_LAT + dly[p];
      end
      exp_end = (abort_at >= 0) ? abort_at + 1 : t + 1;

      start = 1'b1;
      @(posedge clk); #1;
      cyc       = 1;
      valid_at  = -1;
      last_addr = 0;
      end_cyc   = -1;
      excl_bad  = 1'b0;
      hold_bad  = 1'b0;
      while (end_cyc < 0 && cyc < 4000) begin
         start        = 1'b0;
         abort        = 1'b0;
         win_rd_valid = 1'b0;
         if (!busy) begin
            end_cyc = cyc;
         end else begin
            if (int'(win_rd_en) + int'(loadWinReg) + int'(loadAccSumReg) + int'(result_valid) > 1)
               excl_bad = 1'b1;
            if (win_rd_en) begin
               fetch_c.push_back(cyc);
               fetch_a.push_back(int'(win_rd_addr));
               last_addr = int'(win_rd_addr);
               valid_at  = cyc + dly[win_rd_addr];
            end else if (valid_at >= cyc &&
                         (int'(win_rd_addr) != last_addr || loadWinReg || loadAccSumReg)) begin
               hold_bad = 1'b1;
            end
            if (loadWinReg)    ldwin_c.push_back(cyc);
            if (loadAccSumReg) ldacc_c.push_back(cyc);
            if (result_valid)  rv_c.push_back(cyc);
            win_rd_valid = (cyc == valid_at);
            abort        = (cyc == abort_at);
            start        = (start_mid && cyc == 10) || (start_on_rv && result_valid);
            @(posedge clk); #1;
            cyc++;
         end
      end
      start        = 1'b0;
      abort        = 1'b0;
      win_rd_valid = 1'b0;

      chk({nm, " end_cycle"}, end_cyc, exp_end);
      chk({nm, " strobe_exclusive"}, excl_bad, 0);
      chk({nm, " addr_hold"}, hold_bad, 0);
      chk({nm, " fetch_count"}, fetch_c.size(), ef_c.size());
      for (int i = 0; i < ef_c.size(); i++) begin
         chk($sformatf("%s fetch_cyc%0d", nm, i), (i < fetch_c.size()) ? fetch_c[i] : -1, ef_c[i]);
         chk($sformatf("%s fetch_addr%0d", nm, i), (i < fetch_a.size()) ? fetch_a[i] : -1, ef_a[i]);
      end
      chk({nm, " ldwin_count"}, ldwin_c.size(), ew_c.size());
      for (int i = 0; i < ew_c.size(); i++)
         chk($sformatf("%s ldwin_cyc%0d", nm, i), (i < ldwin_c.size()) ? ldwin_c[i] : -1, ew_c[i]);
      chk({nm, " ldacc_count"}, ldacc_c.size(), ea_c.size());
      for (int i = 0; i < ea_c.size(); i++)
         chk($sformatf("%s ldacc_cyc%0d", nm, i), (i < ldacc_c.size()) ? ldacc_c[i] : -1, ea_c[i]);

      if (abort_at < 0) begin
         chk({nm, " rv_count"}, rv_c.size(), 1);
         chk({nm, " rv_cycle"}, (rv_c.size() > 0) ? rv_c[0] : -1, t);
         if (exp_rv >= 0) chk({nm, " rv_cycle_const"}, (rv_c.size() > 0) ? rv_c[0] : -1, exp_rv);
         chk({nm, " best_score"}, best_score, exp_score);
         chk({nm, " best_pos"}, best_pos, exp_pos);
      end else begin
         chk({nm, " rv_count"}, rv_c.size(), 0);
      end

      @(posedge clk); #1;
      chk({nm, " idle_after"}, busy, 0);
      if (abort_at < 0) begin
         chk({nm, " best_score_hold"}, best_score, exp_score);
         chk({nm, " best_pos_hold"}, best_pos, exp_pos);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " busy"}, busy, 0);
      chk({nm, " win_rd_en"}, win_rd_en, 0);
      chk({nm, " win_rd_addr"}, win_rd_addr, 0);
      chk({nm, " loadWinReg"}, loadWinReg, 0);
      chk({nm, " loadAccSumReg"}, loadAccSumReg, 0);
      chk({nm, " best_score"}, best_score, 0);
      chk({nm, " best_pos"}, best_pos, 0);
      chk({nm, " result_valid"}, result_valid, 0);
   endtask

   initial begin
      logic [SCORE_W-1:0] rs;
      logic [POS_W-1:0]   rp;

      checks       = 0;
      errors       = 0;
      rst          = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      win_rd_valid = 1'b0;
      setup(2, -1);

      vecs[0] = '{0, -1, 1'b1, 1'b0, 19'd120,     4'd15, 97};
      vecs[1] = '{1, -1, 1'b0, 1'b1, 19'd900,     4'd5,  97};
      vecs[2] = '{2, -1, 1'b0, 1'b0, 19'd0,       4'd0,  97};
      vecs[3] = '{0,  3, 1'b0, 1'b0, 19'd120,     4'd15, 100};
      vecs[4] = '{3, -1, 1'b0, 1'b0, 19'h7FFF8,   4'd0,  97};

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // abort in idle blocks a simultaneous start
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      chk("idle_abort_blocks_start", busy, 0);
      @(posedge clk); #1;
      chk("idle_abort_still_idle", busy, 0);

      for (int i = 0; i < 5; i++) begin
         setup(vecs[i].kind, vecs[i].slow_pos);
         run_search($sformatf("vec%0d", i), -1, vecs[i].start_mid, vecs[i].start_on_rv,
                    vecs[i].exp_score, vecs[i].exp_pos, vecs[i].exp_rv);
      end

      // abort during the SAMPLE cycle of the last position, then a clean rerun
      setup(0, -1);
      run_search("abort15", 96, 1'b0, 1'b0, '0, '0, -1);
      run_search("after_abort", -1, 1'b0, 1'b0, 19'd120, 4'd15, 97);

      // reset while in LOGW of position 2
      setup(0, -1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 15; c++) begin
         win_rd_valid = (c % 6 == 2);
         @(posedge clk); #1;
      end
      win_rd_valid = 1'b0;
      chk("logw busy", busy, 1);
      chk("logw addr", win_rd_addr, 2);
      chk("logw partial_best", best_score, 8);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk_all_zero("mid_reset");
      @(posedge clk); #1;
      chk("mid_reset_no_rv", result_valid, 0);

      // randomized searches against the reference model
      for (int r = 0; r < 4; r++) begin
         int hi;
         hi = (r % 2 == 1) ? 3 : 65535;
         for (int p = 0; p < NUM_POS; p++) begin
            dly[p] = $urandom_range(1, 4);
            for (int l = 0; l < NUM_LANES; l++) lane_val[p][l] = ACC_W'($urandom_range(0, hi));
         end
         ref_best(rs, rp);
         run_search($sformatf("rand%0d", r), -1, 1'b0, 1'b0, rs, rp, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
